// File: rtl/stopwatch_bcd_counter_pkg.sv
// Shared types and digit limits for the four-digit BCD stopwatch.
// Imported by the counter top and by each digit cell.
package stopwatch_pkg;

   typedef logic [3:0] digit_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam digit_t TENTHS_MAX = 4'd9;
   localparam digit_t ONES_MAX   = 4'd9;
   localparam digit_t TENS_MAX   = 4'd5;

   function automatic digit_t clamp_digit(input digit_t v, input digit_t max);
      return (v > max) ? max : v;
   endfunction

endpackage

// File: rtl/stopwatch_bcd_counter_digit.sv
// One up/down BCD digit wrapping at DIGIT_MAX.
// co is the ripple enable for the next digit.
module bcd_digit
   import stopwatch_pkg::*;
#(
   parameter digit_t DIGIT_MAX = 4'd9
) (
   input  logic   clk,
   input  logic   rst,
   input  logic   en,
   input  logic   up,
   input  logic   load,
   input  digit_t load_val,
   input  logic   clr,
   output digit_t q,
   output logic   co
);

   digit_t r_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_q <= '0;
      end else if (clr) begin
         r_q <= '0;
      end else if (load) begin
         r_q <= load_val;
      end else if (en) begin
         if (up) r_q <= (r_q == DIGIT_MAX) ? 4'd0 : r_q + 4'd1;
         else    r_q <= (r_q == 4'd0) ? DIGIT_MAX : r_q - 4'd1;
      end
   end

   assign q  = r_q;
   assign co = en && (up ? (r_q == DIGIT_MAX) : (r_q == 4'd0));

endmodule

// File: rtl/stopwatch_bcd_counter.sv
// Four-digit BCD stopwatch (M:SS.t): control FSM, terminal detect and a
// ripple-enabled chain of bcd_digit cells.
module stopwatch_bcd_counter
   import stopwatch_pkg::*;
#(
   parameter int MAX_MINS = 9
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       up,
   input  logic       deciClk,
   input  logic       start,
   input  logic       pause,
   input  logic       clear,
   input  logic       load,
   input  logic [3:0] load_mins,
   input  logic [3:0] load_tens,
   input  logic [3:0] load_ones,
   input  logic [3:0] load_tenths,
   output logic [3:0] mins,
   output logic [3:0] tens,
   output logic [3:0] ones,
   output logic [3:0] tenths,
   output logic       running,
   output logic       done,
   output logic       done_pulse
);

   localparam digit_t MINS_MAX = digit_t'(MAX_MINS);

   state_t r_state, w_state_nxt;
   logic   r_running, r_done, r_done_pulse;
   logic   w_tick, w_load_en, w_dp_nxt;
   logic   w_at_term, w_last_step;
   logic   w_co_tenths, w_co_ones, w_co_tens, w_co_mins;
   digit_t w_mins, w_tens, w_ones, w_tenths;

   // Terminal for the current direction, and "the next tick lands on it".
   always_comb begin
      if (up) begin
         w_at_term   = (w_mins == MINS_MAX) && (w_tens == TENS_MAX) &&
                       (w_ones == ONES_MAX) && (w_tenths == TENTHS_MAX);
         w_last_step = (w_mins == MINS_MAX) && (w_tens == TENS_MAX) &&
                       (w_ones == ONES_MAX) && (w_tenths == TENTHS_MAX - 4'd1);
      end else begin
         w_at_term   = (w_mins == 4'd0) && (w_tens == 4'd0) &&
                       (w_ones == 4'd0) && (w_tenths == 4'd0);
         w_last_step = (w_mins == 4'd0) && (w_tens == 4'd0) &&
                       (w_ones == 4'd0) && (w_tenths == 4'd1);
      end
   end

   // Each control consumes its edge even when ignored in the current state.
   always_comb begin
      w_state_nxt = r_state;
      w_tick      = 1'b0;
      w_load_en   = 1'b0;
      w_dp_nxt    = 1'b0;
      if (clear) begin
         w_state_nxt = IDLE;
      end else if (load) begin
         if (r_state != RUN) begin
            w_load_en   = 1'b1;
            w_state_nxt = IDLE;
         end
      end else if (start) begin
         if (r_state == IDLE || r_state == PAUSE) begin
            if (w_at_term) begin
               w_state_nxt = DONE;
               w_dp_nxt    = 1'b1;
            end else begin
               w_state_nxt = RUN;
            end
         end
      end else if (pause) begin
         if (r_state == RUN) w_state_nxt = PAUSE;
      end else if (deciClk && r_state == RUN) begin
         // A direction flip can leave RUN parked on a terminal; stop rather than wrap.
         if (w_at_term) begin
            w_state_nxt = DONE;
            w_dp_nxt    = 1'b1;
         end else begin
            w_tick = 1'b1;
            if (w_last_step) begin
               w_state_nxt = DONE;
               w_dp_nxt    = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= IDLE;
         r_running    <= 1'b0;
         r_done       <= 1'b0;
         r_done_pulse <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_running    <= (w_state_nxt == RUN);
         r_done       <= (w_state_nxt == DONE);
         r_done_pulse <= w_dp_nxt;
      end
   end

   bcd_digit #(.DIGIT_MAX(TENTHS_MAX)) u_tenths (
      .clk(clk), .rst(rst), .en(w_tick), .up(up), .load(w_load_en),
      .load_val(clamp_digit(load_tenths, TENTHS_MAX)), .clr(clear),
      .q(w_tenths), .co(w_co_tenths)
   );

   bcd_digit #(.DIGIT_MAX(ONES_MAX)) u_ones (
      .clk(clk), .rst(rst), .en(w_co_tenths), .up(up), .load(w_load_en),
      .load_val(clamp_digit(load_ones, ONES_MAX)), .clr(clear),
      .q(w_ones), .co(w_co_ones)
   );

   bcd_digit #(.DIGIT_MAX(TENS_MAX)) u_tens (
      .clk(clk), .rst(rst), .en(w_co_ones), .up(up), .load(w_load_en),
      .load_val(clamp_digit(load_tens, TENS_MAX)), .clr(clear),
      .q(w_tens), .co(w_co_tens)
   );

   bcd_digit #(.DIGIT_MAX(MINS_MAX)) u_mins (
      .clk(clk), .rst(rst), .en(w_co_tens), .up(up), .load(w_load_en),
      .load_val(clamp_digit(load_mins, MINS_MAX)), .clr(clear),
      .q(w_mins), .co(w_co_mins)
   );

   assign mins       = w_mins;
   assign tens       = w_tens;
   assign ones       = w_ones;
   assign tenths     = w_tenths;
   assign running    = r_running;
   assign done       = r_done;
   assign done_pulse = r_done_pulse;

endmodule

// File: tb/tb_stopwatch_bcd_counter.sv
// Table-driven scoreboard bench for stopwatch_bcd_counter (MAX_MINS=9).
module tb_stopwatch_bcd_counter;

   logic       clk = 1'b0, rst = 1'b1, up = 1'b1, deciClk = 1'b0;
   logic       start = 1'b0, pause = 1'b0, clear = 1'b0, load = 1'b0;
   logic [3:0] load_mins = '0, load_tens = '0, load_ones = '0, load_tenths = '0;
   logic [3:0] mins, tens, ones, tenths;
   logic       running, done, done_pulse;

   stopwatch_bcd_counter #(.MAX_MINS(9)) dut (
      .clk(clk), .rst(rst), .up(up), .deciClk(deciClk),
      .start(start), .pause(pause), .clear(clear), .load(load),
      .load_mins(load_mins), .load_tens(load_tens),
      .load_ones(load_ones), .load_tenths(load_tenths),
      .mins(mins), .tens(tens), .ones(ones), .tenths(tenths),
      .running(running), .done(done), .done_pulse(done_pulse)
   );

   always #5 clk = ~clk;

   // ctl = {clear, load, start, pause, deciClk}; flags = {running, done, done_pulse}
   localparam logic [4:0] NOP = 5'b00000, CLR = 5'b10000, LD = 5'b01000,
                          ST = 5'b00100, PS = 5'b00010, DC = 5'b00001;
   localparam logic [2:0] F_IDLE = 3'b000, F_RUN = 3'b100,
                          F_DONE = 3'b010, F_DNP = 3'b011;

   typedef struct {
      logic [4:0]  ctl;
      logic        up;
      logic [15:0] ldv;
      logic [18:0] exp;
   } vec_t;

   vec_t        vecs[$];
   logic [18:0] sb_q[$];
   int          checks = 0, failures = 0;
   logic        g_up = 1'b1;

   function automatic logic [18:0] actual();
      return {mins, tens, ones, tenths, running, done, done_pulse};
   endfunction

   task automatic compare(input string name, input logic [18:0] act, input logic [18:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got digits %h flags(run,done,pulse) %b, expected digits %h flags %b",
                  name, act[18:3], act[2:0], exp[18:3], exp[2:0]);
      end
   endtask

   task automatic add(input logic [4:0] ctl, input logic [15:0] ldv,
                      input logic [15:0] dig, input logic [2:0] fl);
      vec_t v;
      v.ctl = ctl; v.up = g_up; v.ldv = ldv; v.exp = {dig, fl};
      vecs.push_back(v);
   endtask

   task automatic apply(input string name, input vec_t v);
      @(negedge clk);
      {clear, load, start, pause, deciClk} = v.ctl;
      up = v.up;
      {load_mins, load_tens, load_ones, load_tenths} = v.ldv;
      sb_q.push_back(v.exp);
      @(posedge clk);
      #1;
      compare(name, actual(), sb_q.pop_front());
   endtask

   task automatic step(input string name, input logic [4:0] ctl, input logic [15:0] ldv,
                       input logic [15:0] dig, input logic [2:0] fl);
      vec_t v;
      v.ctl = ctl; v.up = g_up; v.ldv = ldv; v.exp = {dig, fl};
      apply(name, v);
   endtask

   initial begin
      // 1: count up 12 ticks, then pause freezes the digits
      g_up = 1'b1;
      add(ST, 16'h0, 16'h0000, F_RUN);
      for (int i = 1; i <= 12; i++) add(DC, 16'h0, {8'h00, 4'(i / 10), 4'(i % 10)}, F_RUN);
      add(PS, 16'h0, 16'h0012, F_IDLE);
      for (int i = 0; i < 5; i++) add(DC, 16'h0, 16'h0012, F_IDLE);
      // 2: tens 5->0 carry into mins
      add(CLR, 16'h0, 16'h0000, F_IDLE);
      add(LD, 16'h0598, 16'h0598, F_IDLE);
      add(ST, 16'h0, 16'h0598, F_RUN);
      add(DC, 16'h0, 16'h0599, F_RUN);
      add(DC, 16'h0, 16'h1000, F_RUN);
      add(LD, 16'h3333, 16'h1000, F_RUN);      // load ignored while running
      // 3: up terminal, one-cycle done_pulse, no wrap
      add(CLR, 16'h0, 16'h0000, F_IDLE);
      add(LD, 16'h9597, 16'h9597, F_IDLE);
      add(ST, 16'h0, 16'h9597, F_RUN);
      add(DC, 16'h0, 16'h9598, F_RUN);
      add(DC, 16'h0, 16'h9599, F_DNP);
      add(DC, 16'h0, 16'h9599, F_DONE);
      add(NOP, 16'h0, 16'h9599, F_DONE);
      // 4: down count to terminal, then full borrow chain
      g_up = 1'b0;
      add(LD, 16'h0002, 16'h0002, F_IDLE);
      add(ST, 16'h0, 16'h0002, F_RUN);
      add(DC, 16'h0, 16'h0001, F_RUN);
      add(DC, 16'h0, 16'h0000, F_DNP);
      add(NOP, 16'h0, 16'h0000, F_DONE);
      add(LD, 16'h1000, 16'h1000, F_IDLE);
      add(ST, 16'h0, 16'h1000, F_RUN);
      add(DC, 16'h0, 16'h0599, F_RUN);
      // direction flip mid-run takes effect on the next tick
      g_up = 1'b1;
      add(DC, 16'h0, 16'h1000, F_RUN);
      add(PS, 16'h0, 16'h1000, F_IDLE);
      add(ST | PS, 16'h0, 16'h1000, F_RUN);    // start beats pause
      add(PS, 16'h0, 16'h1000, F_IDLE);
      // 5: clamped load lands on the up terminal; start goes straight to DONE
      add(LD, 16'hF7CB, 16'h9599, F_IDLE);
      add(ST, 16'h0, 16'h9599, F_DNP);
      add(NOP, 16'h0, 16'h9599, F_DONE);
      // start at the down terminal
      add(CLR, 16'h0, 16'h0000, F_IDLE);
      g_up = 1'b0;
      add(ST, 16'h0, 16'h0000, F_DNP);
      add(NOP, 16'h0, 16'h0000, F_DONE);

      repeat (2) @(negedge clk);
      compare("reset_state", actual(), {16'h0000, F_IDLE});
      rst = 1'b0;

      for (int i = 0; i < vecs.size(); i++) apply($sformatf("vec%0d", i), vecs[i]);

      // 6: async reset between edges, then clear beats load
      g_up = 1'b1;
      step("t6_clr", CLR, 16'h0, 16'h0000, F_IDLE);
      step("t6_start", ST, 16'h0, 16'h0000, F_RUN);
      for (int i = 1; i <= 3; i++)
         step($sformatf("t6_dc%0d", i), DC, 16'h0, {12'h000, 4'(i)}, F_RUN);
      @(negedge clk);
      {clear, load, start, pause, deciClk} = 5'b00001;
      #2 rst = 1'b1;
      #1 compare("async_reset", actual(), {16'h0000, F_IDLE});
      @(negedge clk);
      rst = 1'b0;
      step("post_reset_idle", DC, 16'h0, 16'h0000, F_IDLE);
      step("t6_load", LD, 16'h3214, 16'h3214, F_IDLE);
      step("clear_over_load", CLR | LD, 16'h5555, 16'h0000, F_IDLE);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/stopwatch_bcd_counter.md
Name: stopwatch_bcd_counter

Overview:
- Four-digit BCD timer that produces the mins/tens/ones/tenths digits that the terminal-count detect and display logic consume.
- Counts up from 0:00.0 to MAX_MINS:59.9, or down to 0:00.0, advancing once per deciClk qualifier. It stops itself at the terminal value.
- Controlled by start/pause/clear/load from the front-panel debouncers. Reports completion on done and done_pulse.

Parameters:
MAX_MINS, 9, upper limit of the minutes digit (0..9); sets the up-count terminal value and the load clamp.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
up  in  1  count direction: 1 = up, 0 = down
deciClk  in  1  tenth-second qualifier, one clk cycle wide, synchronous to clk
start  in  1  begin or resume counting (pulse)
pause  in  1  freeze counting (pulse)
clear  in  1  return to 0:00.0, IDLE (pulse)
load  in  1  preset digits from load_* (pulse)
load_mins, load_tens, load_ones, load_tenths  in  4 each  preset values
mins, tens, ones, tenths  out  4 each  current BCD digits
running  out  1  high while in RUN
done  out  1  high while in DONE
done_pulse  out  1  one-cycle pulse on entry to DONE

Behaviour:
- Reset (async, rst=1): all digits 0, state IDLE, running/done/done_pulse 0. Reset mid-count discards progress. First state change after release is on the first clk edge with rst=0.
- States: IDLE, RUN, PAUSE, DONE. All outputs are registered; every control takes effect at the clk edge where it is sampled.
- Control priority per edge: clear > load > start > pause > tick.
- clear, from any state: digits 0:00.0, state IDLE, done 0.
- load, accepted in IDLE/PAUSE/DONE and ignored in RUN:
  - Each digit is clamped: tenths/ones >9 -> 9; tens >5 -> 5; mins >MAX_MINS -> MAX_MINS.
  - State goes to IDLE.
- start:
  - From IDLE/PAUSE with digits not at the current-direction terminal: go to RUN.
  - If digits are already at terminal: go to DONE and pulse done_pulse; digits unchanged.
  - Ignored in RUN and DONE.
- pause: RUN -> PAUSE. Ignored elsewhere.
- Tick = deciClk=1 while in RUN and no higher-priority control that cycle. Digits update at that edge, so latency is 1 clk from the deciClk sample.
- Up count:
  - tenths 9->0 carries into ones; ones 9->0 carries into tens; tens 5->0 carries into mins.
  - Terminal is MAX_MINS:59.9.
- Down count:
  - tenths 0->9 borrows from ones; ones 0->9 borrows from tens; tens 0->5 borrows from mins.
  - Terminal is 0:00.0.
- Terminal reached: on the tick edge that writes the terminal value, state goes to DONE and done_pulse=1 for exactly that one registered cycle. Digits hold; the counter never wraps past terminal.
- up changed mid-RUN: the next tick uses the new direction. The terminal check always uses the current up.
- deciClk held high several cycles: one tick per cycle (clock-enable semantics). Upstream guarantees single-cycle pulses.
- start and pause on the same edge: start wins.
- running = (state==RUN); done = (state==DONE).

Decomposition:
- Package stopwatch_pkg holds:
  - state enum (IDLE, RUN, PAUSE, DONE);
  - digit limit constants TENTHS_MAX=9, ONES_MAX=9, TENS_MAX=5;
  - 4-bit BCD digit type.
- Sub-module bcd_digit (parameter DIGIT_MAX): one up/down digit with en, up, load, load_val, clr inputs and a carry/borrow out. Carry/borrow out is combinational: en && (up ? q==DIGIT_MAX : q==0).
- The top chains four bcd_digit instances (ripple enable) and holds the FSM and terminal compare.

Test Plan:
1. Reset, start, up=1, 12 deciClk pulses -> digits 0:01.2, running=1; pause, 5 more pulses -> still 0:01.2, running=0.
2. Load 0:59.8, up=1, start, 2 pulses -> 0:59.9 then 1:00.0 (tens 5->0 carry into mins checked).
3. Load 9:59.7, up=1, start, 3 pulses -> reaches 9:59.9 on pulse 2 with done_pulse for 1 cycle and done=1; pulse 3 leaves digits at 9:59.9.
4. Load 0:00.2, up=0, start, 2 pulses -> 0:00.1, 0:00.0, then DONE; load 1:00.0, one down pulse -> 0:59.9 (borrow chain).
5. Load values 15/7/12/11 -> clamps to 9:59.9 (MAX_MINS=9); start with up=1 -> DONE immediately, done_pulse 1 cycle.
6. Assert rst asynchronously mid-RUN, between clk edges -> digits 0:00.0, done/running 0 before the next edge; clear and load on the same edge -> clear wins.
